// File: rtl/pwm_duty_gen.sv
// PWM waveform generator driven by the rising edges of a divided clock (pwm_clk).
// Each rising edge is one PWM time step. The high time per period comes from a
// double-buffered duty value, and a new duty value takes effect only at a period
// boundary, so the output never glitches when the duty changes.
module pwm_duty_gen #(
  parameter int unsigned  PERIOD = 100,
  parameter int unsigned  DW     = 8,
  localparam int unsigned CW     = $clog2(PERIOD)
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          pwm_clk,
  input  logic          enable,
  input  logic [DW-1:0] duty,
  input  logic          duty_load,
  output logic          pwm_out,
  output logic          period_start,
  output logic          duty_pending
);

  // Compare width wide enough for both cnt+1 (no wrap) and the duty value.
  localparam int unsigned XW      = (CW + 1 > DW) ? CW + 1 : DW;
  localparam logic [CW-1:0] CntLast = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DutyMax = DW'(PERIOD);

  logic          pwm_clk_q;
  logic          tick;
  logic          wrap;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] duty_shadow_q, duty_shadow_d;
  logic [DW-1:0] duty_active_q, duty_active_d;
  logic [DW-1:0] duty_clamped;
  logic          pwm_out_q, pwm_out_d;
  logic          period_start_q, period_start_d;
  logic          duty_pending_q, duty_pending_d;
  logic [XW-1:0] cnt_inc;
  logic [XW-1:0] active_ext;

  assign tick       = pwm_clk & ~pwm_clk_q;
  assign wrap       = tick & (cnt_q == CntLast);
  assign cnt_inc    = XW'(cnt_q) + XW'(1);
  assign active_ext = XW'(duty_active_q);

  // Requests above a full period saturate to 100 % high.
  always_comb begin
    duty_clamped = duty;
    if (duty > DutyMax) begin
      duty_clamped = DutyMax;
    end
  end

  // Next-state: shadow loads, tick counting, period wrap and output level.
  always_comb begin
    cnt_d          = cnt_q;
    duty_shadow_d  = duty_shadow_q;
    duty_active_d  = duty_active_q;
    pwm_out_d      = pwm_out_q;
    period_start_d = 1'b0;
    duty_pending_d = duty_pending_q;

    if (!enable) begin
      // Parked at the last tick so the first tick after enabling starts a period.
      cnt_d     = CntLast;
      pwm_out_d = 1'b0;
    end else if (wrap) begin
      cnt_d          = '0;
      duty_active_d  = duty_shadow_q;
      pwm_out_d      = (duty_shadow_q != '0);
      period_start_d = 1'b1;
      duty_pending_d = 1'b0;
    end else if (tick) begin
      cnt_d     = cnt_q + CW'(1);
      pwm_out_d = (cnt_inc < active_ext);
    end

    // A load coincident with a wrap is kept for the following period.
    if (duty_load) begin
      duty_shadow_d  = duty_clamped;
      duty_pending_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clkin) begin
    if (rst) begin
      // pwm_clk_q starts high so leaving reset with pwm_clk high is not a tick.
      pwm_clk_q      <= 1'b1;
      cnt_q          <= CntLast;
      duty_shadow_q  <= '0;
      duty_active_q  <= '0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      duty_pending_q <= 1'b0;
    end else begin
      pwm_clk_q      <= pwm_clk;
      cnt_q          <= cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      duty_active_q  <= duty_active_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      duty_pending_q <= duty_pending_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign duty_pending = duty_pending_q;

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Bench for pwm_duty_gen at PERIOD=10: pwm_clk toggles every 2 clkin cycles,
// so one tick every 4 cycles and one PWM period every 40 cycles.
module tb_pwm_duty_gen;

  localparam int unsigned P  = 10;
  localparam int unsigned DW = 8;
  localparam int          PC = 40;  // clkin cycles per PWM period

  logic          clkin;
  logic          rst;
  logic          pwm_clk;
  logic          enable;
  logic [DW-1:0] duty;
  logic          duty_load;
  logic          pwm_out;
  logic          period_start;
  logic          duty_pending;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  int ph;

  pwm_duty_gen #(
    .PERIOD(P),
    .DW    (DW)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .pwm_clk     (pwm_clk),
    .enable      (enable),
    .duty        (duty),
    .duty_load   (duty_load),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .duty_pending(duty_pending)
  );

  // clkin period 10; pwm_clk changes 2 time units after a rising clkin edge.
  initial begin
    clkin   = 0;
    pwm_clk = 0;
    ph      = 3;
    forever begin
      #5 clkin = 1;
      #2 ph = (ph + 1) % 4;
      pwm_clk = (ph < 2);
      #3 clkin = 0;
    end
  end

  // Behavioural model: position within the period, applied duty, shadow duty.
  int pos = P - 1;
  int applied = 0;
  int shadow = 0;
  int old_shadow;
  bit m_pend = 0, m_pwm = 0, m_ps = 0, m_prev = 1, m_tick;

  initial begin
    forever begin
      @(posedge clkin);
      if (rst) begin
        pos = P - 1; applied = 0; shadow = 0;
        m_pend = 0; m_pwm = 0; m_ps = 0; m_prev = 1;
      end else begin
        m_tick     = pwm_clk && !m_prev;
        m_prev     = pwm_clk;
        m_ps       = 0;
        old_shadow = shadow;
        if (!enable) begin
          pos   = P - 1;
          m_pwm = 0;
        end else if (m_tick) begin
          pos = (pos + 1) % P;
          if (pos == 0) begin
            applied = old_shadow;
            m_ps    = 1;
            m_pend  = 0;
          end
          m_pwm = (pos < applied);
        end
        if (duty_load) begin
          shadow = (int'(duty) > P) ? P : int'(duty);
          m_pend = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clkin);
      if (chk_en) begin
        n_tests += 3;
        if (pwm_out !== m_pwm) begin
          n_fail++;
          $display("FAIL cyc_pwm_out t=%0t: got %0d, expected %0d", $time, pwm_out, m_pwm);
        end
        if (period_start !== m_ps) begin
          n_fail++;
          $display("FAIL cyc_period_start t=%0t: got %0d, expected %0d", $time,
                   period_start, m_ps);
        end
        if (duty_pending !== m_pend) begin
          n_fail++;
          $display("FAIL cyc_duty_pending t=%0t: got %0d, expected %0d", $time,
                   duty_pending, m_pend);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic wait_ps(input string name, input int max);
    int k;
    k = 0;
    while (period_start !== 1'b1 && k < max) begin
      @(negedge clkin);
      k++;
    end
    check(name, int'(period_start), 1);
  endtask

  // Runs one period from a period_start cycle, optionally pulsing duty_load at
  // cycle offsets la1/la2, and checks high/pending counts and the next start.
  task automatic run_period(input string name, input int exp_highs, input int exp_pend,
                            input int exp_pend_end, input int la1, input int lv1,
                            input int la2, input int lv2);
    int highs, pend;
    highs = 0;
    pend  = 0;
    for (int i = 0; i < PC; i++) begin
      if (pwm_out) highs++;
      if (duty_pending) pend++;
      if (i == la1) begin duty = DW'(lv1); duty_load = 1; end
      if (i == la2) begin duty = DW'(lv2); duty_load = 1; end
      @(negedge clkin);
      duty_load = 0;
    end
    check({name, ".highs"}, highs, exp_highs);
    check({name, ".pend_cycles"}, pend, exp_pend);
    check({name, ".next_start"}, int'(period_start), 1);
    check({name, ".pend_end"}, int'(duty_pending), exp_pend_end);
  endtask

  initial begin
    rst       = 1;
    enable    = 0;
    duty      = '0;
    duty_load = 0;
    step(1);
    chk_en = 1;
    step(2);
    check("rst.pwm_out", int'(pwm_out), 0);
    check("rst.period_start", int'(period_start), 0);
    check("rst.duty_pending", int'(duty_pending), 0);

    // Duty 3: 12 cycles high, 28 low per period.
    rst       = 0;
    duty      = 8'd3;
    duty_load = 1;
    step(1);
    duty_load = 0;
    check("load3.pending", int'(duty_pending), 1);
    enable = 1;
    wait_ps("first_start", 8);
    check("first_start.pending_clear", int'(duty_pending), 0);
    check("first_start.pwm_out", int'(pwm_out), 1);
    run_period("d3a", 12, 0, 0, -1, 0, -1, 0);
    run_period("d3b", 12, 0, 0, -1, 0, -1, 0);

    // Duty 0, 10 and clamped 25.
    run_period("ld0", 12, 34, 0, 5, 0, -1, 0);
    run_period("d0", 0, 0, 0, -1, 0, -1, 0);
    run_period("ld10", 0, 34, 0, 5, 10, -1, 0);
    run_period("d10", 40, 0, 0, -1, 0, -1, 0);
    run_period("ld25", 40, 34, 0, 5, 25, -1, 0);
    run_period("d25", 40, 0, 0, -1, 0, -1, 0);

    // Mid-period load of 7 while running 3.
    run_period("ld3", 40, 34, 0, 5, 3, -1, 0);
    run_period("ld7", 12, 31, 0, 8, 7, -1, 0);
    // Shadow 2 loaded mid-period, then 5 loaded on the wrap cycle.
    run_period("ld2_5", 28, 35, 1, 4, 2, 39, 5);
    run_period("d2", 8, 40, 0, -1, 0, -1, 0);
    run_period("d5", 20, 0, 0, -1, 0, -1, 0);

    // Enable dropped at tick 2 with duty 6, then re-enabled.
    run_period("ld6", 20, 34, 0, 5, 6, -1, 0);
    step(8);
    check("pre_disable.pwm_out", int'(pwm_out), 1);
    enable = 0;
    step(1);
    check("disable.pwm_out", int'(pwm_out), 0);
    step(10);
    check("disabled.pwm_out", int'(pwm_out), 0);
    check("disabled.period_start", int'(period_start), 0);
    enable = 1;
    wait_ps("reenable_start", 8);
    check("reenable.pwm_out", int'(pwm_out), 1);
    run_period("reen", 24, 0, 0, -1, 0, -1, 0);

    // Reset in the high phase while pwm_clk has just risen.
    step(2);
    for (int k = 0; k < 8 && ph != 0; k++) step(1);
    check("pre_rst.pwm_clk_rose", ph, 0);
    check("pre_rst.pwm_out", int'(pwm_out), 1);
    rst = 1;
    step(1);
    rst = 0;
    check("rst_mid.pwm_out", int'(pwm_out), 0);
    check("rst_mid.period_start", int'(period_start), 0);
    check("rst_mid.duty_pending", int'(duty_pending), 0);
    step(1);
    check("no_false_tick", int'(period_start), 0);
    wait_ps("post_rst_start", 8);
    check("post_rst.pwm_out", int'(pwm_out), 0);
    run_period("post_rst", 0, 0, 0, -1, 0, -1, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
